exec_sequencer: RTL and testbench

//  Multi-cycle execution controller between instruction decode and the PC/regfile.
//  - Single-cycle opcodes: advances the PC and enables register writeback every cycle.
//  - MLT/MLTI: stalls the PC for the iterative multiplier's latency.
//  - STIN/LOUT: stalls on a valid/ready handshake with the switch and LED ports.
//  - Output qualifiers gate the decoder's reg_write and the PC register.

---
 rtl/proc_pkg.sv | 23 ++
 rtl/exec_sequencer_if.sv | 23 ++
 rtl/exec_sequencer.sv | 102 ++++++++++
 tb/tb_exec_sequencer.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/proc_pkg.sv
// Shared processor definitions: opcode encodings and the execution sequencer state type.
package proc_pkg;

  localparam logic [5:0] OP_NOP  = 6'h00;
  localparam logic [5:0] OP_ADD  = 6'h01;
  localparam logic [5:0] OP_SUB  = 6'h02;
  localparam logic [5:0] OP_ADDI = 6'h03;
  localparam logic [5:0] OP_SUBI = 6'h04;
  localparam logic [5:0] OP_MLT  = 6'h05;
  localparam logic [5:0] OP_MLTI = 6'h06;
  localparam logic [5:0] OP_BEQ  = 6'h07;
  localparam logic [5:0] OP_JMP  = 6'h08;
  localparam logic [5:0] OP_STIN = 6'h09;
  localparam logic [5:0] OP_LOUT = 6'h0A;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MUL      = 2'd1,
    WAIT_IN  = 2'd2,
    WAIT_OUT = 2'd3
  } state_t;

endpackage

// File: rtl/exec_sequencer_if.sv
// Decode/IO-side signals of the execution sequencer; master = decode/IO, slave = sequencer.
interface exec_sequencer_if;
  logic [5:0] opcode;
  logic       in_valid;
  logic       out_ready;
  logic       pc_en;
  logic       wb_en;
  logic       mul_start;
  logic       in_ack;
  logic       out_valid;
  logic       busy;
  logic       illegal;

  modport master (
    output opcode, in_valid, out_ready,
    input  pc_en, wb_en, mul_start, in_ack, out_valid, busy, illegal
  );

  modport slave (
    input  opcode, in_valid, out_ready,
    output pc_en, wb_en, mul_start, in_ack, out_valid, busy, illegal
  );
endinterface

// File: rtl/exec_sequencer.sv
// Multi-cycle execution controller: gates PC advance and register writeback while
// multiplies or switch/LED handshakes are outstanding. Outputs are Mealy, zero latency.
module exec_sequencer
  import proc_pkg::*;
#(
  parameter int MUL_CYCLES = 8,
  parameter int CNT_W      = 4
) (
  input  logic              clk,
  input  logic              rst,
  exec_sequencer_if.slave   bus
);

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt,   w_cnt_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= RUN;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    bus.pc_en     = 1'b0;
    bus.wb_en     = 1'b0;
    bus.mul_start = 1'b0;
    bus.in_ack    = 1'b0;
    bus.out_valid = 1'b0;
    bus.busy      = 1'b0;
    bus.illegal   = 1'b0;
    // Reset masks every strobe so an aborted instruction leaves no trace.
    if (!rst) begin
      bus.busy = (r_state != RUN);
      unique case (r_state)
        RUN: begin
          unique case (bus.opcode)
            OP_NOP, OP_BEQ, OP_JMP: bus.pc_en = 1'b1;
            OP_ADD, OP_SUB, OP_ADDI, OP_SUBI: begin
              bus.pc_en = 1'b1;
              bus.wb_en = 1'b1;
            end
            OP_MLT, OP_MLTI: begin
              bus.mul_start = 1'b1;
              w_cnt_nxt     = CNT_W'(MUL_CYCLES - 2);
              w_state_nxt   = MUL;
            end
            OP_STIN: begin
              if (bus.in_valid) begin
                bus.in_ack = 1'b1;
                bus.wb_en  = 1'b1;
                bus.pc_en  = 1'b1;
              end else begin
                w_state_nxt = WAIT_IN;
              end
            end
            OP_LOUT: begin
              bus.out_valid = 1'b1;
              if (bus.out_ready) bus.pc_en = 1'b1;
              else               w_state_nxt = WAIT_OUT;
            end
            default: begin
              bus.illegal = 1'b1;
              bus.pc_en   = 1'b1;
            end
          endcase
        end
        MUL: begin
          if (r_cnt != '0) begin
            w_cnt_nxt = r_cnt - 1'b1;
          end else begin
            bus.wb_en   = 1'b1;
            bus.pc_en   = 1'b1;
            w_state_nxt = RUN;
          end
        end
        WAIT_IN: begin
          if (bus.in_valid) begin
            bus.in_ack  = 1'b1;
            bus.wb_en   = 1'b1;
            bus.pc_en   = 1'b1;
            w_state_nxt = RUN;
          end
        end
        WAIT_OUT: begin
          bus.out_valid = 1'b1;
          if (bus.out_ready) begin
            bus.pc_en   = 1'b1;
            w_state_nxt = RUN;
          end
        end
        default: w_state_nxt = RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_exec_sequencer.sv
// Directed-vector bench for exec_sequencer (MUL_CYCLES=8).
// Output vector order: {pc_en, wb_en, mul_start, in_ack, out_valid, busy, illegal}.
module tb_exec_sequencer;
  import proc_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec  = 0;
  int   n_fail = 0;

  exec_sequencer_if bus ();

  exec_sequencer #(.MUL_CYCLES(8), .CNT_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  logic [6:0] outs;
  assign outs = {bus.pc_en, bus.wb_en, bus.mul_start, bus.in_ack,
                 bus.out_valid, bus.busy, bus.illegal};

  task automatic drive(input logic r, input logic [5:0] op, input logic iv, input logic ordy);
    rst           = r;
    bus.opcode    = op;
    bus.in_valid  = iv;
    bus.out_ready = ordy;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic       r  [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    logic [5:0] op [4] = '{OP_ADD, OP_LOUT, OP_NOP, OP_ADD};
    logic [6:0] ex [4] = '{7'b0000000, 7'b0000000, 7'b1000000, 7'b1100000};
    for (int i = 0; i < 4; i++) begin
      drive(r[i], op[i], 1'b1, 1'b1);
      @(negedge clk);
      n_vec++;
      if (outs !== ex[i]) begin
        n_fail++;
        $display("FAIL reset[%0d]: outs=%b expected=%b", i, outs, ex[i]);
      end
      next_cycle();
    end
  endtask

  task automatic test_single_cycle();
    logic [5:0] op [9] = '{OP_NOP, OP_BEQ, OP_JMP, OP_ADD, OP_SUB, OP_ADDI, OP_SUBI, OP_STIN, OP_LOUT};
    logic [6:0] ex [9] = '{7'b1000000, 7'b1000000, 7'b1000000, 7'b1100000, 7'b1100000,
                           7'b1100000, 7'b1100000, 7'b1101000, 7'b1000100};
    for (int i = 0; i < 9; i++) begin
      drive(1'b0, op[i], 1'b1, 1'b1);
      @(negedge clk);
      n_vec++;
      if (outs !== ex[i]) begin
        n_fail++;
        $display("FAIL single[%0d] op=%h: outs=%b expected=%b", i, op[i], outs, ex[i]);
      end
      next_cycle();
    end
  endtask

  // MLT, garbage opcode while busy (must be ignored), retire, then back-to-back MLTI.
  task automatic test_back_to_back();
    logic [6:0] ex;
    logic [5:0] op;
    for (int i = 0; i < 17; i++) begin
      if (i == 0)                op = OP_MLT;
      else if (i == 8)           op = OP_MLTI;
      else if (i == 16)          op = OP_NOP;
      else                       op = 6'h3F;
      if (i == 0 || i == 8)      ex = 7'b0010000;
      else if (i == 7 || i == 15) ex = 7'b1100010;
      else if (i == 16)          ex = 7'b1000000;
      else                       ex = 7'b0000010;
      drive(1'b0, op, 1'b0, 1'b0);
      @(negedge clk);
      n_vec++;
      if (outs !== ex) begin
        n_fail++;
        $display("FAIL mul[%0d]: outs=%b expected=%b", i, outs, ex);
      end
      next_cycle();
    end
  endtask

  task automatic test_stin_wait();
    logic [6:0] ex [7] = '{7'b0000000, 7'b0000010, 7'b0000010, 7'b0000010,
                           7'b0000010, 7'b1101010, 7'b1000000};
    logic       iv [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 7; i++) begin
      drive(1'b0, (i == 6) ? OP_NOP : OP_STIN, iv[i], 1'b0);
      @(negedge clk);
      n_vec++;
      if (outs !== ex[i]) begin
        n_fail++;
        $display("FAIL stin[%0d]: outs=%b expected=%b", i, outs, ex[i]);
      end
      next_cycle();
    end
  endtask

  task automatic test_lout_wait();
    logic [6:0] ex [5] = '{7'b0000100, 7'b0000110, 7'b0000110, 7'b1000110, 7'b1000000};
    logic       rd [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, (i == 4) ? OP_NOP : OP_LOUT, 1'b0, rd[i]);
      @(negedge clk);
      n_vec++;
      if (outs !== ex[i]) begin
        n_fail++;
        $display("FAIL lout[%0d]: outs=%b expected=%b", i, outs, ex[i]);
      end
      next_cycle();
    end
  endtask

  // Unrecognised opcode, also with in_valid high: illegal never coincides with in_ack.
  task automatic test_illegal();
    logic [5:0] op [3] = '{6'h3F, 6'h20, OP_NOP};
    logic [6:0] ex [3] = '{7'b1000001, 7'b1000001, 7'b1000000};
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, op[i], (i == 1), 1'b0);
      @(negedge clk);
      n_vec++;
      if (outs !== ex[i]) begin
        n_fail++;
        $display("FAIL illegal[%0d]: outs=%b expected=%b", i, outs, ex[i]);
      end
      next_cycle();
    end
  endtask

  // Reset at MUL cnt=3 aborts silently; then reset during WAIT_OUT drops out_valid.
  task automatic test_reset_abort();
    logic       r  [11] = '{0, 0, 0, 0, 1, 1, 0, 0, 1, 0, 0};
    logic [5:0] op [11] = '{OP_MLT, OP_MLT, OP_MLT, OP_MLT, OP_MLT, OP_MLT, OP_ADD,
                            OP_LOUT, OP_LOUT, OP_NOP, OP_ADD};
    logic [6:0] ex [11] = '{7'b0010000, 7'b0000010, 7'b0000010, 7'b0000010, 7'b0000000,
                            7'b0000000, 7'b1100000, 7'b0000100, 7'b0000000, 7'b1000000,
                            7'b1100000};
    for (int i = 0; i < 11; i++) begin
      drive(r[i], op[i], 1'b0, 1'b0);
      @(negedge clk);
      n_vec++;
      if (outs !== ex[i]) begin
        n_fail++;
        $display("FAIL abort[%0d]: outs=%b expected=%b", i, outs, ex[i]);
      end
      next_cycle();
    end
  endtask

  initial begin
    drive(1'b1, OP_NOP, 1'b0, 1'b0);
    next_cycle();
    test_reset();
    test_single_cycle();
    test_back_to_back();
    test_stin_wait();
    test_lout_wait();
    test_illegal();
    test_reset_abort();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
